// File: rtl/posit_pkg.sv
// Shared posit constants, sequencer state encoding and special-value helpers.
package posit_pkg;

  localparam int          POSIT_W    = 32;
  localparam logic [31:0] POSIT_NAR  = 32'h8000_0000;
  localparam logic [31:0] POSIT_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } seq_state_e;

  function automatic logic is_nar(input logic [POSIT_W-1:0] p);
    return p == POSIT_NAR;
  endfunction

  function automatic logic is_zero(input logic [POSIT_W-1:0] p);
    return p == POSIT_ZERO;
  endfunction

endpackage

// File: rtl/posit_sync_fifo.sv
// Synchronous FIFO with occupancy count; full is registered so the producer sees a clean ready.
module posit_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) count_d = count_q + CNT_W'(1);
    else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PTR_W'(1);
      if (pop_i)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/posit_mul_sequencer.sv
// Issue/collect sequencer for the posit multiplier core: FIFO-buffered operands, one op in flight,
// zero/NaR short-circuit, stale-done protection and timeout recovery.
module posit_mul_sequencer
  import posit_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [POSIT_W-1:0]           in_a,
  input  logic [POSIT_W-1:0]           in_b,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         mul_start,
  output logic [POSIT_W-1:0]           mul_a,
  output logic [POSIT_W-1:0]           mul_b,
  input  logic [POSIT_W-1:0]           mul_result,
  input  logic                         mul_done,
  input  logic                         mul_nar,
  input  logic                         mul_zero,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [POSIT_W-1:0]           out_result,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_nar,
  output logic                         out_zero,
  output logic                         out_timeout,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int FIFO_W = TAG_W + 2 * POSIT_W;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  seq_state_e          state_q, state_d;
  logic [POSIT_W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                nar_q, nar_d, zero_q, zero_d, to_q, to_d;
  logic                arm_q, arm_d;
  logic [TO_W-1:0]     tmo_q, tmo_d;

  logic                push, pop, load_head, fifo_full, fifo_empty;
  logic [FIFO_W-1:0]   head;
  logic [POSIT_W-1:0]  head_a, head_b;
  logic [TAG_W-1:0]    head_tag;

  assign push = in_valid && !fifo_full;
  assign {head_tag, head_b, head_a} = head;

  posit_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_tag, in_b, in_a}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    res_d     = res_q;
    nar_d     = nar_q;
    zero_d    = zero_q;
    to_d      = to_q;
    arm_d     = arm_q;
    tmo_d     = tmo_q;
    load_head = 1'b0;
    pop       = 1'b0;

    unique case (state_q)
      ST_IDLE:  load_head = !fifo_empty;
      ST_ISSUE: begin
        arm_d   = 1'b0;
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_d = tmo_q + TO_W'(1);
        // Only a done that follows a low sample belongs to this operation.
        if (arm_q && mul_done) begin
          res_d   = mul_result;
          nar_d   = mul_nar;
          zero_d  = mul_zero && !mul_nar;
          to_d    = 1'b0;
          state_d = ST_HOLD;
        end else if (tmo_q == TO_W'(TIMEOUT)) begin
          res_d   = POSIT_NAR;
          nar_d   = 1'b1;
          zero_d  = 1'b0;
          to_d    = 1'b1;
          state_d = ST_HOLD;
        end else if (!mul_done) begin
          arm_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (!fifo_empty) load_head = 1'b1;
          else             state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared pop path for IDLE and back-to-back HOLD; NaR outranks zero.
    if (load_head) begin
      pop   = 1'b1;
      a_d   = head_a;
      b_d   = head_b;
      tag_d = head_tag;
      if (is_nar(head_a) || is_nar(head_b)) begin
        res_d   = POSIT_NAR;
        nar_d   = 1'b1;
        zero_d  = 1'b0;
        to_d    = 1'b0;
        state_d = ST_HOLD;
      end else if (is_zero(head_a) || is_zero(head_b)) begin
        res_d   = POSIT_ZERO;
        nar_d   = 1'b0;
        zero_d  = 1'b1;
        to_d    = 1'b0;
        state_d = ST_HOLD;
      end else begin
        state_d = ST_ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      nar_q   <= 1'b0;
      zero_q  <= 1'b0;
      to_q    <= 1'b0;
      arm_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      nar_q   <= nar_d;
      zero_q  <= zero_d;
      to_q    <= to_d;
      arm_q   <= arm_d;
      tmo_q   <= tmo_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign mul_start   = (state_q == ST_ISSUE);
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign out_valid   = (state_q == ST_HOLD);
  assign out_result  = res_q;
  assign out_tag     = tag_q;
  assign out_nar     = nar_q;
  assign out_zero    = zero_q;
  assign out_timeout = to_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_posit_mul_sequencer.sv
// Self-checking bench: behavioural core model plus scoreboard, directed scenarios then random traffic.
module tb_posit_mul_sequencer;

  localparam int          DEPTH   = 4;
  localparam int          TAG_W   = 4;
  localparam int          TIMEOUT = 40;
  localparam logic [31:0] NAR     = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                       in_valid, in_ready, mul_start, mul_done, mul_nar, mul_zero;
  logic                       out_valid, out_ready, out_nar, out_zero, out_timeout, busy;
  logic [31:0]                in_a, in_b, mul_a, mul_b, mul_result, out_result;
  logic [TAG_W-1:0]           in_tag, out_tag;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;

  posit_mul_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_done(mul_done), .mul_nar(mul_nar), .mul_zero(mul_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .out_nar(out_nar), .out_zero(out_zero), .out_timeout(out_timeout),
    .busy(busy), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             nar;
    logic             zero;
    logic             to;
  } exp_t;
  typedef struct { int mode; int lat; } core_t;   // mode 0 normal, 1 stale done, 2 hang

  exp_t  sb[$];
  core_t cq[$];
  int    n_chk = 0, n_fail = 0, cyc = 0, n_start = 0, push_edge = 0;
  int    cur_mode = 0, cur_lat = 2;
  bit    rnd_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in arithmetic for the core; any deterministic function of (a,b) works for sequencing.
  function automatic logic [31:0] core_f(input logic [31:0] a, input logic [31:0] b);
    return a ^ {b[15:0], b[31:16]};
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] t, input int mode);
    exp_t e;
    logic [31:0] r;
    e.tag = t; e.nar = 0; e.zero = 0; e.to = 0;
    if (a == NAR || b == NAR)    begin e.res = NAR; e.nar = 1; end
    else if (a == 0 || b == 0)   begin e.res = 0; e.zero = 1; end
    else if (mode == 2)          begin e.res = NAR; e.nar = 1; e.to = 1; end
    else begin
      r = core_f(a, b);
      e.res = r; e.nar = (r == NAR); e.zero = (r == 0);
    end
    return e;
  endfunction

  // Core model: per-op behaviour is taken from cq in issue order.
  initial begin : core
    int    c_pend, c_stale, c_lat, c_mode;
    logic [31:0] r;
    core_t c;
    mul_done = 0; mul_result = 0; mul_nar = 0; mul_zero = 0;
    c_pend = 0; c_stale = 0; c_lat = 0; c_mode = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        c_pend = 0;
        mul_done = 0;
      end else if (mul_start) begin
        n_start++;
        chk("start_has_queued_op", cq.size() != 0, 1);
        if (cq.size() != 0) begin c = cq.pop_front(); c_mode = c.mode; c_lat = c.lat; end
        else begin c_mode = 0; c_lat = 2; end
        c_pend  = 1;
        c_stale = (c_mode == 1) ? 5 : 0;
        if (c_stale == 0) mul_done = 0;
      end else if (c_pend != 0) begin
        if (c_stale > 0) begin
          c_stale--;
          if (c_stale == 0) mul_done = 0;
        end else if (c_mode == 2) begin
          mul_done = 0;
        end else if (c_lat > 1) begin
          c_lat--;
        end else begin
          r = core_f(mul_a, mul_b);
          mul_result = r; mul_nar = (r == NAR); mul_zero = (r == 0);
          mul_done = 1;
          c_pend = 0;
        end
      end
    end
  end

  // Monitor: samples 2 time units after each falling edge, checks outputs and records accepted pushes.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        sb.delete();
        cq.delete();
        continue;
      end
      chk("busy", busy, sb.size() != 0);
      chk("nar_zero_exclusive", out_nar & out_zero, 0);
      chk("timeout_implies_nar", out_timeout & ~out_nar, 0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_beat: got result %h tag %h expected no output (cycle %0d)",
                   out_result, out_tag, cyc);
        end else begin
          e = sb[0];
          chk("out_result", out_result, e.res);
          chk("out_tag", out_tag, e.tag);
          chk("out_nar", out_nar, e.nar);
          chk("out_zero", out_zero, e.zero);
          chk("out_timeout", out_timeout, e.to);
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_a, in_b, in_tag, cur_mode));
        if (!(in_a == NAR || in_b == NAR || in_a == 0 || in_b == 0))
          cq.push_back('{cur_mode, cur_lat});
        push_edge = cyc + 1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Called at a falling edge; returns at a falling edge after the push was accepted.
  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                         input int mode, input int lat);
    int n;
    n = 0;
    in_valid = 1; in_a = a; in_b = b; in_tag = t; cur_mode = mode; cur_lat = lat;
    #2;
    while (!in_ready && n < 1000) begin tick(); #2; n++; end
    chk("push_accepted", in_ready, 1);
    tick();
    in_valid = 0;
  endtask

  // what: 0 mul_start, 1 out_valid, 2 idle. Returns the sample cycle, at the following falling edge.
  task automatic wait_for(input int what, input int budget, input string name, output int at);
    bit found;
    found = 0; at = -1;
    for (int i = 0; i < budget; i++) begin
      #2;
      if ((what == 0 && mul_start) || (what == 1 && out_valid) || (what == 2 && !busy)) begin
        found = 1; at = cyc;
        break;
      end
      tick();
    end
    if (found) tick();
    chk(name, found, 1);
  endtask

  function automatic logic [31:0] pick();
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return NAR;
    if (s == 1) return 32'h0;
    return $urandom;
  endfunction

  initial begin : stim
    int pe, at, at2, ns, acc, tries, m, l;
    logic [31:0] ra, rb;
    in_valid = 0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 0;

    // Reset values
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_mul_a", mul_a, 0);
    tick(); #1 rst_n = 1;
    tick();

    // 1: normal multiply, literal result, start latency
    ns = n_start;
    push_op(32'h4000_0000, 32'h4800_0000, 4'd3, 0, 20);
    pe = push_edge;
    wait_for(0, 10, "t1_wait_start", at);
    chk("t1_start_latency", at, pe + 1);
    wait_for(1, 60, "t1_wait_valid", at);
    #2;
    chk("t1_result_literal", out_result, 32'h4000_4800);
    chk("t1_tag_literal", out_tag, 3);
    chk("t1_flags_literal", {out_nar, out_zero, out_timeout}, 0);
    tick(); out_ready = 1;
    wait_for(2, 20, "t1_idle", at);
    chk("t1_one_start", n_start - ns, 1);

    // 2: stale done held high after the new start
    out_ready = 0;
    ns = n_start;
    push_op(32'h3800_0000, 32'h5000_0001, 4'd5, 1, 4);
    wait_for(1, 60, "t2_wait_valid", at);
    #2;
    chk("t2_result_literal", out_result, 32'h3801_5000);
    tick(); out_ready = 1;
    wait_for(2, 20, "t2_idle", at);
    chk("t2_one_start", n_start - ns, 1);

    // 3: bypass NaR then zero, no core activity
    out_ready = 0;
    ns = n_start;
    push_op(NAR, 32'h0, 4'd5, 0, 2);
    pe = push_edge;
    push_op(32'h0, 32'h4000_0000, 4'd6, 0, 2);
    wait_for(1, 10, "t3_wait_valid", at);
    chk("t3_bypass_latency", at, pe + 1);
    #2;
    chk("t3_nar_literal", {out_result, out_nar}, 33'h1_0000_0001);
    tick(); out_ready = 1;
    wait_for(2, 20, "t3_idle", at);
    chk("t3_no_start", n_start - ns, 0);

    // 4: backpressure until full
    out_ready = 0;
    acc = 0; tries = 0;
    for (int i = 0; i < 20 && acc < DEPTH + 1; i++) begin
      in_valid = 1; in_a = {2'b01, 29'($urandom), 1'b1}; in_b = {2'b00, 29'($urandom), 1'b1};
      in_tag = TAG_W'(acc); cur_mode = 0; cur_lat = 3;
      tries++;
      #2;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 0;
    #2;
    chk("t4_accepted", acc, DEPTH + 1);
    chk("t4_no_stall_before_full", tries, DEPTH + 1);
    chk("t4_in_ready_low", in_ready, 0);
    chk("t4_fifo_count", fifo_count, DEPTH);
    tick(); out_ready = 1;
    wait_for(2, 200, "t4_idle", at);

    // 5: timeout, then the queued op completes normally
    out_ready = 0;
    ns = n_start;
    push_op(32'h3000_0000, 32'h3000_0001, 4'd9, 2, 2);
    push_op(32'h4400_0000, 32'h3c00_0000, 4'd10, 0, 5);
    wait_for(0, 10, "t5_wait_start", at);
    wait_for(1, TIMEOUT + 20, "t5_wait_valid", at2);
    chk("t5_timeout_window", (at2 - at >= TIMEOUT) && (at2 - at <= TIMEOUT + 3), 1);
    #2;
    chk("t5_timeout_literal", {out_result, out_nar, out_timeout}, 34'h2_0000_0003);
    tick(); out_ready = 1;
    wait_for(2, 60, "t5_idle", at);
    chk("t5_two_starts", n_start - ns, 2);

    // 6: reset while waiting on the core
    push_op(32'h4000_0000, 32'h4000_0001, 4'd7, 0, 100);
    wait_for(0, 10, "t6_wait_start", at);
    repeat (4) tick();
    #1 rst_n = 0;
    tick();
    #1 rst_n = 1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_fifo_count", fifo_count, 0);
    chk("t6_busy", busy, 0);
    chk("t6_mul_start", mul_start, 0);
    chk("t6_out_result", out_result, 0);
    tick();
    push_op(32'h4000_0000, 32'h4c00_0000, 4'd8, 0, 3);
    wait_for(2, 40, "t6_recover_idle", at);

    // Random traffic
    rnd_ready = 1;
    for (int k = 0; k < 60; k++) begin
      m  = $urandom_range(0, 15);
      m  = (m == 0) ? 2 : (m <= 4) ? 1 : 0;
      l  = (m == 1) ? $urandom_range(1, 6) : $urandom_range(2, 12);
      ra = pick();
      rb = pick();
      push_op(ra, rb, TAG_W'($urandom), m, l);
      repeat ($urandom_range(0, 3)) tick();
    end
    rnd_ready = 0;
    out_ready = 1;
    wait_for(2, 3000, "rand_idle", at);
    chk("final_scoreboard_empty", sb.size(), 0);
    chk("final_core_queue_empty", cq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
